fetch_decode: RTL and testbench
===============================

Name: fetch_decode

Overview:
- Control front end of the 4-bit CPU. Owns the stage sequencer, the instruction register, the opcode decoder and the architectural register state (REGS).
- Drives the ALU's stage/opecode/imm/cur inputs and commits the ALU's next result back into REGS at the end of EXECUTE.
- Sits between the program ROM and the ALU inside the cpu block.

Parameters:
- RESET_PC, 4'h0, PC value loaded on reset.
- HALT_ON_SELF_JMP, 1, when 1 an executed JMP_IMM whose imm equals the current PC sets halted.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- tick  input  1  clock enable from the slow-clock divider; the stage advances only on clk edges where tick=1
- rom_data  input  8  instruction byte at rom_addr; [7:4] opcode, [3:0] imm; combinational ROM
- alu_next  input  REGS  next-state result from the ALU
- rom_addr  output  4  ROM address, always equal to regs.pc
- stage  output  STAGE  current stage (FETCH, DECODE, EXECUTE)
- opecode  output  OPECODE  decoded operation, registered
- imm  output  4  immediate field, registered
- regs  output  REGS  architectural state {a, b, out, pc, carry}; feeds the ALU cur input
- led_out  output  4  regs.out
- halted  output  1  CPU stopped on a self-jump

Behaviour:
- Reset (async, rst=1) values:
  - stage=FETCH; ir=8'h00; opecode=NOP; imm=0; halted=0.
  - regs.a=0, regs.b=0, regs.out=0, regs.carry=0, regs.pc=RESET_PC.
  - Reset asserted mid-instruction abandons that instruction; no partial commit.
- State machine. All transitions require tick=1; with tick=0 every register holds.
  - FETCH -> DECODE: ir <= rom_data (rom_addr = regs.pc).
  - DECODE -> EXECUTE: opecode <= decode(ir[7:4]); imm <= ir[3:0].
  - EXECUTE -> FETCH: regs <= alu_next. This is the only cycle in which regs changes.
- One instruction takes exactly 3 ticks. regs.pc updates only through alu_next; this block never increments the PC itself.
- Decode map (opcode nibble -> OPECODE):
  - 0000 ADD_A_IMM; 0001 MOV_A_B; 0010 IN_A; 0011 MOV_A_IMM
  - 0100 MOV_B_A; 0101 ADD_B_IMM; 0110 IN_B; 0111 MOV_B_IMM
  - 1001 OUT_B; 1011 OUT_IMM; 1110 JNC_IMM; 1111 JMP_IMM
  - all other nibbles -> NOP
- alu_next is sampled only at the EXECUTE -> FETCH edge. The ALU output is undefined in other stages and is ignored there.
- Halt:
  - Condition: HALT_ON_SELF_JMP=1, stage=EXECUTE, opecode=JMP_IMM, imm==regs.pc, tick=1.
  - Result: commit as normal, halted <= 1, stage <= FETCH.
  - While halted=1 the stage stays at FETCH and regs holds, regardless of tick.
  - Only rst clears halted.
- A self-jump via JNC_IMM does not halt.
- PC wrap (15 -> 0) is the ALU's responsibility; this block passes it through unchanged.
- tick held high continuously gives one stage per clk.

Decomposition:
- lib_stage: STAGE enum {FETCH, DECODE, EXECUTE}.
- lib_operation: OPECODE enum, adding NOP as an explicit member, plus the opcode nibble localparams.
- lib_cpu: REGS packed struct {a[3:0], b[3:0], out[3:0], pc[3:0], carry}.
- The nibble-to-OPECODE map is a function opcode_decode in lib_operation, not a sub-module.
- One sub-module, stage_sequencer: the stage FSM, tick gating and halt hold. It is small, but the bench reuses it when driving the ALU alone.

Test Plan:
- Reset: assert rst asynchronously mid-DECODE -> same cycle stage=FETCH, regs.pc=0, opecode=NOP, halted=0, with no clk edge needed.
- Tick gating: ROM[0]=8'h33, tick pulsed every 4th clk -> stage advances once per tick; after 3 ticks regs.a=3, regs.pc=1; regs unchanged on non-tick clks.
- Program with the real alu, tick=1: 33, 05, 40, 9?, 00 -> after each EXECUTE:
  - a=3
  - a=8
  - b=8
  - out=8 (led_out=4'h8)
  - pc increments by 1 each instruction
- Carry/JNC: ROM 3F, 01, E0, 30, F4 -> 4'hF+1 sets carry=1, a=0; JNC falls through to pc=3; a=0; pc=4 JMP 4 self -> halted=1; extra ticks leave pc=4 and a unchanged.
- Undefined opcode: ROM[0]=8'h8A -> opecode=NOP in EXECUTE, imm=4'hA; only pc changes (0 -> 1) per the ALU nop.
- Halt disabled: HALT_ON_SELF_JMP=0, ROM[0]=8'hF0 -> halted stays 0; stage keeps cycling FETCH/DECODE/EXECUTE with pc=0.

Source files
------------

// File: rtl/fetch_decode_pkg.sv
// Shared types for the 4-bit CPU front end: stage encoding, decoded
// operation set, architectural register struct and the opcode decoder.
package fetch_decode_pkg;

  // Instruction stages. Each instruction walks FETCH -> DECODE -> EXECUTE.
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DECODE  = 2'd1,
    EXECUTE = 2'd2
  } stage_e;

  // Raw opcode nibbles as they appear in rom_data[7:4].
  localparam logic [3:0] OP_ADD_A_IMM = 4'b0000;
  localparam logic [3:0] OP_MOV_A_B   = 4'b0001;
  localparam logic [3:0] OP_IN_A      = 4'b0010;
  localparam logic [3:0] OP_MOV_A_IMM = 4'b0011;
  localparam logic [3:0] OP_MOV_B_A   = 4'b0100;
  localparam logic [3:0] OP_ADD_B_IMM = 4'b0101;
  localparam logic [3:0] OP_IN_B      = 4'b0110;
  localparam logic [3:0] OP_MOV_B_IMM = 4'b0111;
  localparam logic [3:0] OP_OUT_B     = 4'b1001;
  localparam logic [3:0] OP_OUT_IMM   = 4'b1011;
  localparam logic [3:0] OP_JNC_IMM   = 4'b1110;
  localparam logic [3:0] OP_JMP_IMM   = 4'b1111;

  // Decoded operations. Defined opcodes keep their nibble as the encoding;
  // NOP borrows 4'b1000, one of the nibbles that decodes to NOP anyway.
  typedef enum logic [3:0] {
    ADD_A_IMM = 4'b0000,
    MOV_A_B   = 4'b0001,
    IN_A      = 4'b0010,
    MOV_A_IMM = 4'b0011,
    MOV_B_A   = 4'b0100,
    ADD_B_IMM = 4'b0101,
    IN_B      = 4'b0110,
    MOV_B_IMM = 4'b0111,
    NOP       = 4'b1000,
    OUT_B     = 4'b1001,
    OUT_IMM   = 4'b1011,
    JNC_IMM   = 4'b1110,
    JMP_IMM   = 4'b1111
  } opecode_e;

  // Architectural state shared with the ALU (cur in, next out).
  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] out;
    logic [3:0] pc;
    logic       carry;
  } regs_t;

  // Opcode nibble to operation; every unlisted nibble is a NOP.
  function automatic opecode_e opcode_decode(input logic [3:0] nibble);
    opecode_e op;
    case (nibble)
      OP_ADD_A_IMM: op = ADD_A_IMM;
      OP_MOV_A_B:   op = MOV_A_B;
      OP_IN_A:      op = IN_A;
      OP_MOV_A_IMM: op = MOV_A_IMM;
      OP_MOV_B_A:   op = MOV_B_A;
      OP_ADD_B_IMM: op = ADD_B_IMM;
      OP_IN_B:      op = IN_B;
      OP_MOV_B_IMM: op = MOV_B_IMM;
      OP_OUT_B:     op = OUT_B;
      OP_OUT_IMM:   op = OUT_IMM;
      OP_JNC_IMM:   op = JNC_IMM;
      OP_JMP_IMM:   op = JMP_IMM;
      default:      op = NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/fetch_decode_stage_sequencer.sv
// Stage FSM for the CPU front end. Advances one stage per tick, emits a
// one-cycle strobe for the register group owned by each stage, and latches
// the halt flag when the executing instruction is a self-jump.
// tick is a plain clock enable, not a handshake: nothing back-pressures it.
module fetch_decode_stage_sequencer
  import fetch_decode_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   tick,
  input  logic   halt_req,
  output stage_e stage,
  output logic   halted,
  output logic   load_ir,
  output logic   load_decode,
  output logic   commit
);

  stage_e state_q;
  stage_e state_d;
  logic   halted_q;
  logic   halted_d;
  logic   advance;

  // Once halted the sequencer ignores tick entirely; only rst resumes it.
  assign advance = tick && !halted_q;
  assign stage   = state_q;
  assign halted  = halted_q;

  // Stage and halt flag registers; reset abandons any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FETCH;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  // Next stage, halt latch and per-stage load strobes.
  always_comb begin
    state_d     = state_q;
    halted_d    = halted_q;
    load_ir     = 1'b0;
    load_decode = 1'b0;
    commit      = 1'b0;
    case (state_q)
      FETCH: begin
        if (advance) begin
          load_ir = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (advance) begin
          load_decode = 1'b1;
          state_d     = EXECUTE;
        end
      end
      EXECUTE: begin
        if (advance) begin
          commit  = 1'b1;
          state_d = FETCH;
          // The self-jump still commits; halting only stops further stages.
          if (halt_req) begin
            halted_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

endmodule

// File: rtl/fetch_decode.sv
// CPU front end: holds the instruction register, the decoded operation and
// immediate, and the architectural registers. The ALU computes the next
// register state; this block only commits it at the end of EXECUTE and
// never touches the PC on its own.
module fetch_decode
  import fetch_decode_pkg::*;
#(
  parameter logic [3:0] RESET_PC         = 4'h0,
  parameter bit         HALT_ON_SELF_JMP = 1'b1
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [7:0] rom_data,
  input  regs_t      alu_next,
  output logic [3:0] rom_addr,
  output stage_e     stage,
  output opecode_e   opecode,
  output logic [3:0] imm,
  output regs_t      regs,
  output logic [3:0] led_out,
  output logic       halted
);

  logic [7:0] ir_q;
  opecode_e   opecode_q;
  logic [3:0] imm_q;
  regs_t      regs_q;

  logic       halt_req;
  logic       load_ir;
  logic       load_decode;
  logic       commit;

  // A JNC to itself is deliberately excluded: it may fall through on carry.
  assign halt_req = HALT_ON_SELF_JMP && (opecode_q == JMP_IMM) &&
                    (imm_q == regs_q.pc);

  fetch_decode_stage_sequencer u_seq (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .halt_req    (halt_req),
    .stage       (stage),
    .halted      (halted),
    .load_ir     (load_ir),
    .load_decode (load_decode),
    .commit      (commit)
  );

  // Instruction register captures the ROM byte at the FETCH -> DECODE edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q <= 8'h00;
    end else if (load_ir) begin
      ir_q <= rom_data;
    end
  end

  // Decoded operation and immediate are updated at the DECODE -> EXECUTE edge
  // and stay stable through EXECUTE, which is what the ALU evaluates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opecode_q <= NOP;
      imm_q     <= 4'h0;
    end else if (load_decode) begin
      opecode_q <= opcode_decode(ir_q[7:4]);
      imm_q     <= ir_q[3:0];
    end
  end

  // Architectural state changes only on the EXECUTE -> FETCH edge; alu_next
  // is undefined in the other stages and never sampled there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q.a     <= 4'h0;
      regs_q.b     <= 4'h0;
      regs_q.out   <= 4'h0;
      regs_q.pc    <= RESET_PC;
      regs_q.carry <= 1'b0;
    end else if (commit) begin
      regs_q <= alu_next;
    end
  end

  assign opecode  = opecode_q;
  assign imm      = imm_q;
  assign regs     = regs_q;
  assign rom_addr = regs_q.pc;
  assign led_out  = regs_q.out;

endmodule

// File: tb/tb_fetch_decode.sv
// Bench for fetch_decode: a small ROM and a behavioural ALU close the loop
// around the DUT; a second instance runs with self-jump halting disabled.
module tb_fetch_decode;
  import fetch_decode_pkg::*;

  localparam logic [3:0] IN_PORT = 4'h6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (halt enabled) ----------------
  logic [7:0] rom [16];
  logic [7:0] rom_data;
  logic [3:0] rom_addr;
  regs_t      alu_next;
  stage_e     stage;
  opecode_e   opecode;
  logic [3:0] imm;
  regs_t      regs;
  logic [3:0] led_out;
  logic       halted;

  // ---------------- DUT (halt disabled) ----------------
  logic [7:0] rom_nh [16];
  logic [7:0] rom_data_nh;
  logic [3:0] rom_addr_nh;
  regs_t      alu_next_nh;
  stage_e     stage_nh;
  opecode_e   opecode_nh;
  logic [3:0] imm_nh;
  regs_t      regs_nh;
  logic [3:0] led_out_nh;
  logic       halted_nh;

  fetch_decode dut (
    .clk(clk), .rst(rst), .tick(tick), .rom_data(rom_data),
    .alu_next(alu_next), .rom_addr(rom_addr), .stage(stage),
    .opecode(opecode), .imm(imm), .regs(regs), .led_out(led_out),
    .halted(halted)
  );

  fetch_decode #(.RESET_PC(4'h0), .HALT_ON_SELF_JMP(1'b0)) dut_nh (
    .clk(clk), .rst(rst), .tick(tick), .rom_data(rom_data_nh),
    .alu_next(alu_next_nh), .rom_addr(rom_addr_nh), .stage(stage_nh),
    .opecode(opecode_nh), .imm(imm_nh), .regs(regs_nh), .led_out(led_out_nh),
    .halted(halted_nh)
  );

  // Behavioural ALU: non-jump ops advance pc by one; only adds produce carry.
  function automatic regs_t alu_model(input regs_t r, input opecode_e op,
                                      input logic [3:0] i);
    regs_t      n;
    logic [4:0] sum;
    n       = r;
    n.pc    = r.pc + 4'd1;
    n.carry = 1'b0;
    sum     = 5'd0;
    case (op)
      ADD_A_IMM: begin sum = {1'b0, r.a} + {1'b0, i}; n.a = sum[3:0]; n.carry = sum[4]; end
      MOV_A_B:   n.a = r.b;
      IN_A:      n.a = IN_PORT;
      MOV_A_IMM: n.a = i;
      MOV_B_A:   n.b = r.a;
      ADD_B_IMM: begin sum = {1'b0, r.b} + {1'b0, i}; n.b = sum[3:0]; n.carry = sum[4]; end
      IN_B:      n.b = IN_PORT;
      MOV_B_IMM: n.b = i;
      OUT_B:     n.out = r.b;
      OUT_IMM:   n.out = i;
      JNC_IMM:   if (!r.carry) n.pc = i;
      JMP_IMM:   n.pc = i;
      default:   ;
    endcase
    return n;
  endfunction

  assign rom_data    = rom[rom_addr];
  assign rom_data_nh = rom_nh[rom_addr_nh];

  // ALU models for both instances.
  always_comb begin
    alu_next    = alu_model(regs, opecode, imm);
    alu_next_nh = alu_model(regs_nh, opecode_nh, imm_nh);
  end

  function automatic regs_t mk_regs(input logic [3:0] a, input logic [3:0] b,
                                    input logic [3:0] o, input logic [3:0] pc,
                                    input logic c);
    regs_t r;
    r.a = a; r.b = b; r.out = o; r.pc = pc; r.carry = c;
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic t);
    @(negedge clk);
    tick = t;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    tick = 1'b0;
    rst  = 1'b1;
    #2;
    rst  = 1'b0;
  endtask

  typedef struct {
    logic [7:0] instr;
    opecode_e   op;
    regs_t      exp;
    logic       exp_halted;
  } prog_vec_t;

  typedef struct {
    logic     tick_v;
    stage_e   exp_stage;
    logic [3:0] exp_a;
    logic [3:0] exp_pc;
  } tick_vec_t;

  typedef struct {
    logic [3:0] nibble;
    opecode_e   op;
  } dec_vec_t;

  // One full instruction with tick held high, checking every stage.
  task automatic run_vec(input prog_vec_t v, input int idx);
    step(1'b1);
    check($sformatf("prog%0d_stage_decode", idx), stage, DECODE);
    step(1'b1);
    check($sformatf("prog%0d_stage_execute", idx), stage, EXECUTE);
    check($sformatf("prog%0d_opecode", idx), opecode, v.op);
    check($sformatf("prog%0d_imm", idx), imm, v.instr[3:0]);
    step(1'b1);
    check($sformatf("prog%0d_stage_fetch", idx), stage, FETCH);
    check($sformatf("prog%0d_regs", idx), regs, v.exp);
    check($sformatf("prog%0d_led_out", idx), led_out, v.exp.out);
    check($sformatf("prog%0d_halted", idx), halted, v.exp_halted);
  endtask

  prog_vec_t prog_a [5];
  prog_vec_t prog_b [5];
  prog_vec_t prog_u [1];
  tick_vec_t tick_tab [12];
  dec_vec_t  dec_tab [16];

  initial begin
    // ---- vector tables ----
    prog_a[0] = '{8'h33, MOV_A_IMM, mk_regs(4'h3, 4'h0, 4'h0, 4'h1, 1'b0), 1'b0};
    prog_a[1] = '{8'h05, ADD_A_IMM, mk_regs(4'h8, 4'h0, 4'h0, 4'h2, 1'b0), 1'b0};
    prog_a[2] = '{8'h40, MOV_B_A,   mk_regs(4'h8, 4'h8, 4'h0, 4'h3, 1'b0), 1'b0};
    prog_a[3] = '{8'h90, OUT_B,     mk_regs(4'h8, 4'h8, 4'h8, 4'h4, 1'b0), 1'b0};
    prog_a[4] = '{8'h00, ADD_A_IMM, mk_regs(4'h8, 4'h8, 4'h8, 4'h5, 1'b0), 1'b0};

    prog_b[0] = '{8'h3F, MOV_A_IMM, mk_regs(4'hF, 4'h0, 4'h0, 4'h1, 1'b0), 1'b0};
    prog_b[1] = '{8'h01, ADD_A_IMM, mk_regs(4'h0, 4'h0, 4'h0, 4'h2, 1'b1), 1'b0};
    prog_b[2] = '{8'hE0, JNC_IMM,   mk_regs(4'h0, 4'h0, 4'h0, 4'h3, 1'b0), 1'b0};
    prog_b[3] = '{8'h30, MOV_A_IMM, mk_regs(4'h0, 4'h0, 4'h0, 4'h4, 1'b0), 1'b0};
    prog_b[4] = '{8'hF4, JMP_IMM,   mk_regs(4'h0, 4'h0, 4'h0, 4'h4, 1'b0), 1'b1};

    prog_u[0] = '{8'h8A, NOP,       mk_regs(4'h0, 4'h0, 4'h0, 4'h1, 1'b0), 1'b0};

    // tick on every 4th clk: stage moves at clk 3, 7, 11; commit at clk 11
    for (int i = 0; i < 12; i++) begin
      tick_tab[i].tick_v    = (i % 4 == 3);
      tick_tab[i].exp_stage = (i < 3) ? FETCH : (i < 7) ? DECODE :
                              (i < 11) ? EXECUTE : FETCH;
      tick_tab[i].exp_a     = (i < 11) ? 4'h0 : 4'h3;
      tick_tab[i].exp_pc    = (i < 11) ? 4'h0 : 4'h1;
    end

    dec_tab[0]  = '{4'h0, ADD_A_IMM}; dec_tab[1]  = '{4'h1, MOV_A_B};
    dec_tab[2]  = '{4'h2, IN_A};      dec_tab[3]  = '{4'h3, MOV_A_IMM};
    dec_tab[4]  = '{4'h4, MOV_B_A};   dec_tab[5]  = '{4'h5, ADD_B_IMM};
    dec_tab[6]  = '{4'h6, IN_B};      dec_tab[7]  = '{4'h7, MOV_B_IMM};
    dec_tab[8]  = '{4'h8, NOP};       dec_tab[9]  = '{4'h9, OUT_B};
    dec_tab[10] = '{4'hA, NOP};       dec_tab[11] = '{4'hB, OUT_IMM};
    dec_tab[12] = '{4'hC, NOP};       dec_tab[13] = '{4'hD, NOP};
    dec_tab[14] = '{4'hE, JNC_IMM};   dec_tab[15] = '{4'hF, JMP_IMM};

    for (int i = 0; i < 16; i++) begin
      rom[i]    = 8'h00;
      rom_nh[i] = 8'hF0;
    end

    // ---- reset state ----
    #12;
    check("reset_stage", stage, FETCH);
    check("reset_opecode", opecode, NOP);
    check("reset_imm", imm, 4'h0);
    check("reset_regs", regs, mk_regs(4'h0, 4'h0, 4'h0, 4'h0, 1'b0));
    check("reset_halted", halted, 1'b0);
    check("reset_rom_addr", rom_addr, 4'h0);
    rst = 1'b0;

    // ---- tick gating ----
    rom[0] = 8'h33;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(tick_tab[i].tick_v);
      check($sformatf("tick%0d_stage", i), stage, tick_tab[i].exp_stage);
      check($sformatf("tick%0d_a", i), regs.a, tick_tab[i].exp_a);
      check($sformatf("tick%0d_pc", i), regs.pc, tick_tab[i].exp_pc);
    end

    // ---- decode map ----
    for (int i = 0; i < 16; i++) begin
      rom[0] = {dec_tab[i].nibble, 4'h5};
      do_reset();
      step(1'b1);
      step(1'b1);
      check($sformatf("dec%0h_opecode", dec_tab[i].nibble), opecode, dec_tab[i].op);
      check($sformatf("dec%0h_imm", dec_tab[i].nibble), imm, 4'h5);
    end

    // ---- async reset mid-DECODE ----
    rom[0] = 8'h33;
    rom[1] = 8'h05;
    do_reset();
    step(1'b1); step(1'b1); step(1'b1);
    step(1'b1);
    check("midrst_pre_stage", stage, DECODE);
    check("midrst_pre_pc", regs.pc, 4'h1);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_stage", stage, FETCH);
    check("midrst_pc", regs.pc, 4'h0);
    check("midrst_a", regs.a, 4'h0);
    check("midrst_opecode", opecode, NOP);
    check("midrst_halted", halted, 1'b0);
    tick = 1'b0;
    #1;
    rst = 1'b0;

    // ---- program A: mov/add/mov/out/add ----
    for (int i = 0; i < 5; i++) rom[i] = prog_a[i].instr;
    do_reset();
    for (int i = 0; i < 5; i++) run_vec(prog_a[i], i);

    // ---- program B: carry, JNC fall-through, self-jump halt ----
    for (int i = 0; i < 5; i++) rom[i] = prog_b[i].instr;
    do_reset();
    for (int i = 0; i < 5; i++) run_vec(prog_b[i], 10 + i);
    for (int i = 0; i < 6; i++) begin
      step(1'b1);
      check($sformatf("halt_hold%0d_stage", i), stage, FETCH);
    end
    check("halt_hold_regs", regs, mk_regs(4'h0, 4'h0, 4'h0, 4'h4, 1'b0));
    check("halt_hold_halted", halted, 1'b1);
    do_reset();
    #1;
    check("halt_cleared_by_rst", halted, 1'b0);
    check("halt_rst_pc", regs.pc, 4'h0);

    // ---- undefined opcode ----
    rom[0] = prog_u[0].instr;
    do_reset();
    run_vec(prog_u[0], 20);

    // ---- halt disabled: JMP 0 at pc 0 keeps cycling ----
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(1'b1);
      check($sformatf("nohalt%0d_stage", i), stage_nh, stage_e'((i + 1) % 3));
      check($sformatf("nohalt%0d_halted", i), halted_nh, 1'b0);
      check($sformatf("nohalt%0d_pc", i), regs_nh.pc, 4'h0);
    end

    // ---- final report ----
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so a stuck run still terminates.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
